// File: rtl/mem_ctrl_pkg.sv
// Shared encodings and default sizes for the MEM-stage
// stall controller.
package mem_ctrl_pkg;

   localparam int ADDR_W_D  = 32;
   localparam int DATA_W_D  = 32;
   localparam int TIMEOUT_D = 64;
   localparam int CNT_W_D   = 16;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mem_wdog.sv
// Watchdog counter bounding one memory wait.
// Fires expire once the count reaches TIMEOUT-1.
module mem_wdog #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int W = $clog2(TIMEOUT);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
      end
   end

   assign expire = en && (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stall_ctrl.sv
// Sequences multi-cycle data-memory accesses and
// stalls the pipeline until each one completes.
module mem_stall_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_D,
   parameter int DATA_W  = DATA_W_D,
   parameter int TIMEOUT = TIMEOUT_D,
   parameter int CNT_W   = CNT_W_D
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_read_i,
   input  logic              mem_write_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic              hold_o,
   output logic              timeout_o,
   output logic              err_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   state_t state;
   logic   acc;
   logic   in_idle;
   logic   in_wait;
   logic   expire;

   assign acc     = mem_read_i | mem_write_i;
   assign in_idle = (state == S_IDLE);
   assign in_wait = (state == S_WAIT);

   // IDLE stalls combinationally so the access never slips past MEM
   assign hold_o    = ~reset & ((in_idle & acc) | in_wait);
   assign mem_req_o = in_wait;

   mem_wdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk    (clk),
      .reset  (reset),
      .clr    (~in_wait),
      .en     (in_wait),
      .expire (expire)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         rdata_o     <= '0;
         timeout_o   <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         timeout_o <= 1'b0;
         case (state)
            S_IDLE: begin
               if (acc) begin
                  mem_addr_o  <= addr_i;
                  mem_wdata_o <= wdata_i;
                  mem_we_o    <= mem_write_i;
                  state       <= S_WAIT;
               end
            end
            S_WAIT: begin
               // a late ack still beats the watchdog
               if (mem_ack_i) begin
                  if (!mem_we_o) begin
                     rdata_o <= mem_rdata_i;
                  end
                  state <= S_DONE;
               end else if (expire) begin
                  if (!mem_we_o) begin
                     rdata_o <= '0;
                  end
                  timeout_o <= 1'b1;
                  err_o     <= 1'b1;
                  state     <= S_DONE;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_o <= '0;
      end else if (hold_o && (stall_cnt_o != '1)) begin
         stall_cnt_o <= stall_cnt_o
                      + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Directed scoreboard bench for mem_stall_ctrl.
// A second instance with a 2-bit counter covers saturation.
module tb_mem_stall_ctrl;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_read_i;
   logic        mem_write_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;

   logic        mem_req_o, mem_we_o, hold_o;
   logic        timeout_o, err_o;
   logic [31:0] mem_addr_o, mem_wdata_o, rdata_o;
   logic [15:0] stall_cnt_o;

   logic        req2, we2, hold2, to2, err2;
   logic [31:0] addr2, wdata2, rdata2;
   logic [1:0]  cnt2;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        to;
      logic        err;
      int          holds;
      int          reqs;
      logic [15:0] cnt;
      logic [1:0]  cnt2;
   } exp_t;

   exp_t sb[$];

   logic [31:0] m_rdata;
   logic        m_err;
   int          m_cnt;

   always #5 clk = ~clk;

   mem_stall_ctrl #(
      .ADDR_W(32), .DATA_W(32),
      .TIMEOUT(TO), .CNT_W(16)
   ) dut (
      .clk(clk), .reset(reset),
      .mem_read_i(mem_read_i),
      .mem_write_i(mem_write_i),
      .addr_i(addr_i), .wdata_i(wdata_i),
      .mem_ack_i(mem_ack_i),
      .mem_rdata_i(mem_rdata_i),
      .mem_req_o(mem_req_o),
      .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o),
      .rdata_o(rdata_o), .hold_o(hold_o),
      .timeout_o(timeout_o), .err_o(err_o),
      .stall_cnt_o(stall_cnt_o)
   );

   mem_stall_ctrl #(
      .ADDR_W(32), .DATA_W(32),
      .TIMEOUT(TO), .CNT_W(2)
   ) dut2 (
      .clk(clk), .reset(reset),
      .mem_read_i(mem_read_i),
      .mem_write_i(mem_write_i),
      .addr_i(addr_i), .wdata_i(wdata_i),
      .mem_ack_i(mem_ack_i),
      .mem_rdata_i(mem_rdata_i),
      .mem_req_o(req2), .mem_we_o(we2),
      .mem_addr_o(addr2),
      .mem_wdata_o(wdata2),
      .rdata_o(rdata2), .hold_o(hold2),
      .timeout_o(to2), .err_o(err2),
      .stall_cnt_o(cnt2)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      mem_read_i  = 1'b0;
      mem_write_i = 1'b0;
      mem_ack_i   = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset   = 1'b0;
      m_rdata = '0;
      m_err   = 1'b0;
      m_cnt   = 0;
   endtask

   // k = cycle of WAIT carrying the ack (1 = first), 0 = never
   task automatic access(input string tag,
                         input logic rd, input logic wr,
                         input logic [31:0] a,
                         input logic [31:0] wd,
                         input int k,
                         input logic [31:0] rdv);
      exp_t e;
      exp_t g;
      int   h;
      int   r;
      bit   done;
      e.holds = (k == 0) ? TO + 1 : k + 1;
      e.reqs  = e.holds - 1;
      e.to    = (k == 0);
      if (k == 0) m_err = 1'b1;
      if (!wr) m_rdata = (k == 0) ? 32'h0 : rdv;
      m_cnt  += e.holds;
      e.rdata = m_rdata;
      e.err   = m_err;
      e.cnt   = 16'(m_cnt);
      e.cnt2  = (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
      sb.push_back(e);

      @(negedge clk);
      mem_read_i  = rd;
      mem_write_i = wr;
      addr_i      = a;
      wdata_i     = wd;
      #1;
      h    = hold_o ? 1 : 0;
      r    = 0;
      done = 1'b0;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         mem_read_i  = 1'b0;
         mem_write_i = 1'b0;
         addr_i      = $urandom;
         wdata_i     = $urandom;
         mem_ack_i   = (c == k);
         mem_rdata_i = (c == k) ? rdv : $urandom;
         #1;
         if (!hold_o) begin
            done = 1'b1;
            break;
         end
         h++;
         if (mem_req_o) r++;
         if (c == 1) begin
            chk({tag, "_we"}, 32'(mem_we_o), 32'(wr));
            chk({tag, "_addr"}, mem_addr_o, a);
            if (wr) chk({tag, "_wdata"}, mem_wdata_o, wd);
         end
      end
      mem_ack_i = 1'b0;
      chk({tag, "_done"}, 32'(done), 32'd1);
      g = sb.pop_front();
      chk({tag, "_holds"}, 32'(h), 32'(g.holds));
      chk({tag, "_reqs"}, 32'(r), 32'(g.reqs));
      chk({tag, "_req_done"}, 32'(mem_req_o), 32'd0);
      chk({tag, "_rdata"}, rdata_o, g.rdata);
      chk({tag, "_tmo"}, 32'(timeout_o), 32'(g.to));
      chk({tag, "_err"}, 32'(err_o), 32'(g.err));
      chk({tag, "_cnt"}, 32'(stall_cnt_o), 32'(g.cnt));
      chk({tag, "_cnt2"}, 32'(cnt2), 32'(g.cnt2));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      addr_i      = '0;
      wdata_i     = '0;
      mem_rdata_i = '0;
      reset       = 1'b1;
      mem_read_i  = 1'b1;
      mem_write_i = 1'b0;
      mem_ack_i   = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_hold", 32'(hold_o), 32'd0);
      chk("rst_req", 32'(mem_req_o), 32'd0);
      chk("rst_we", 32'(mem_we_o), 32'd0);
      chk("rst_addr", mem_addr_o, 32'd0);
      chk("rst_rdata", rdata_o, 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
      chk("rst_cnt", 32'(stall_cnt_o), 32'd0);
      do_reset();

      access("load", 1'b1, 1'b0, 32'h40, 32'h0,
             3, 32'hDEADBEEF);
      access("store", 1'b0, 1'b1, 32'h80,
             32'h12345678, 1, 32'hA5A5A5A5);
      access("rdwr", 1'b1, 1'b1, 32'hC0,
             32'h0BADF00D, 2, 32'h5A5A5A5A);
      access("ackexp", 1'b1, 1'b0, 32'h44, 32'h0,
             TO, 32'hCAFEF00D);

      do_reset();
      access("ld2a", 1'b1, 1'b0, 32'h100, 32'h0,
             2, 32'h11112222);
      access("ld2b", 1'b1, 1'b0, 32'h104, 32'h0,
             2, 32'h33334444);

      access("tmo", 1'b1, 1'b0, 32'h200, 32'h0,
             0, 32'h0);
      @(negedge clk);
      #1;
      chk("tmo_pulse_end", 32'(timeout_o), 32'd0);
      chk("tmo_err_sticky", 32'(err_o), 32'd1);
      access("after_tmo", 1'b0, 1'b1, 32'h204,
             32'h77, 1, 32'h0);

      do_reset();
      @(negedge clk);
      mem_read_i = 1'b1;
      addr_i     = 32'h300;
      @(negedge clk);
      mem_read_i = 1'b0;
      @(negedge clk);
      #1;
      chk("mid_req", 32'(mem_req_o), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      #1;
      chk("mrst_req", 32'(mem_req_o), 32'd0);
      chk("mrst_hold", 32'(hold_o), 32'd0);
      chk("mrst_addr", mem_addr_o, 32'd0);
      chk("mrst_cnt", 32'(stall_cnt_o), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      mem_ack_i   = 1'b1;
      mem_rdata_i = 32'hFFFF0000;
      #1;
      chk("stray_hold", 32'(hold_o), 32'd0);
      @(negedge clk);
      mem_ack_i = 1'b0;
      #1;
      chk("stray_req", 32'(mem_req_o), 32'd0);
      chk("stray_rdata", rdata_o, 32'd0);
      chk("stray_tmo", 32'(timeout_o), 32'd0);
      chk("stray_cnt", 32'(stall_cnt_o), 32'd0);

      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

endmodule
